// File: rtl/rs_load_buffer.sv
// Multi-entry load reservation station: captures base/offset, snoops the CDB for
// pending bases, and dispatches the oldest READY load to the memory FU.
module rs_load_buffer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 8,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               issue,
   input  logic [31:0]        base_val_in,
   input  logic [TAG_W-1:0]   base_tag_in,
   input  logic               base_rdy_in,
   input  logic [31:0]        offset_in,
   input  logic [2:0]         mem_u_b_h_w_in,
   input  logic [TAG_W+32:0]  cdb,
   input  logic               mem_ready,
   input  logic               FU_result_taken,
   output logic               full,
   output logic [IDX_W-1:0]   alloc_idx,
   output logic               mem_valid,
   output logic [31:0]        mem_addr,
   output logic [2:0]         mem_u_b_h_w,
   output logic [IDX_W-1:0]   mem_idx,
   output logic [DEPTH-1:0]   busy_vec
);

   localparam logic [1:0] ST_FREE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [1:0] ST_EXEC  = 2'd3;

   logic [1:0]       state_q [DEPTH];
   logic [31:0]      base_q  [DEPTH];
   logic [31:0]      off_q   [DEPTH];
   logic [2:0]       type_q  [DEPTH];
   logic [TAG_W-1:0] tag_q   [DEPTH];
   logic [IDX_W-1:0] rank_q  [DEPTH];

   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_data;

   logic             alloc_found;
   logic [IDX_W-1:0] occupancy;
   logic             exec_any;
   logic [IDX_W-1:0] exec_rank;
   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic [IDX_W-1:0] sel_rank;
   logic             do_issue;
   logic             do_dispatch;
   logic             do_free;
   logic [IDX_W-1:0] issue_rank;

   assign cdb_valid = cdb[TAG_W+32];
   assign cdb_tag   = cdb[TAG_W+31:32];
   assign cdb_data  = cdb[31:0];

   // Occupancy never needs to reach DEPTH in this width: it is only consumed on issue, which requires !full.
   always_comb begin
      alloc_idx   = '0;
      alloc_found = 1'b0;
      occupancy   = '0;
      busy_vec    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (state_q[i] != ST_FREE) begin
            busy_vec[i] = 1'b1;
            occupancy   = occupancy + IDX_W'(1);
         end else if (!alloc_found) begin
            alloc_idx   = IDX_W'(i);
            alloc_found = 1'b1;
         end
      end
   end

   assign full = &busy_vec;

   always_comb begin
      exec_any  = 1'b0;
      exec_rank = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_rank  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (state_q[i] == ST_EXEC) begin
            exec_any  = 1'b1;
            exec_rank = rank_q[i];
         end
         if (state_q[i] == ST_READY && (!sel_found || rank_q[i] < sel_rank)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_rank  = rank_q[i];
         end
      end
   end

   assign mem_valid   = sel_found && !exec_any;
   assign mem_addr    = sel_found ? base_q[sel_idx] + off_q[sel_idx] : 32'd0;
   assign mem_u_b_h_w = sel_found ? type_q[sel_idx] : 3'd0;
   assign mem_idx     = sel_found ? sel_idx : '0;

   assign do_issue    = issue && !full;
   assign do_dispatch = mem_valid && mem_ready;
   assign do_free     = FU_result_taken && exec_any;
   // The entry leaving this cycle still counts in occupancy, so discount it to keep ranks dense.
   assign issue_rank  = occupancy - (do_free ? IDX_W'(1) : IDX_W'(0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= ST_FREE;
            base_q[i]  <= '0;
            off_q[i]   <= '0;
            type_q[i]  <= '0;
            tag_q[i]   <= '0;
            rank_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            case (state_q[i])
               ST_FREE: begin
                  if (do_issue && alloc_idx == IDX_W'(i)) begin
                     off_q[i]  <= offset_in;
                     type_q[i] <= mem_u_b_h_w_in;
                     tag_q[i]  <= base_tag_in;
                     rank_q[i] <= issue_rank;
                     if (base_rdy_in) begin
                        state_q[i] <= ST_READY;
                        base_q[i]  <= base_val_in;
                     end else if (cdb_valid && cdb_tag == base_tag_in) begin
                        state_q[i] <= ST_READY;
                        base_q[i]  <= cdb_data;
                     end else begin
                        state_q[i] <= ST_WAIT;
                     end
                  end
               end
               ST_WAIT: begin
                  if (cdb_valid && cdb_tag == tag_q[i]) begin
                     state_q[i] <= ST_READY;
                     base_q[i]  <= cdb_data;
                  end
               end
               ST_READY: begin
                  if (do_dispatch && sel_idx == IDX_W'(i))
                     state_q[i] <= ST_EXEC;
               end
               default: begin
                  if (FU_result_taken)
                     state_q[i] <= ST_FREE;
               end
            endcase
            if (do_free && state_q[i] != ST_FREE && rank_q[i] > exec_rank)
               rank_q[i] <= rank_q[i] - IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rs_load_buffer.sv
// Directed bench for rs_load_buffer: issue, snoop/bypass, age ordering, wrap and async reset.
module tb_rs_load_buffer;

   localparam int DEPTH = 4;
   localparam int TAG_W = 8;
   localparam int IDX_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              issue;
   logic [31:0]       base_val_in;
   logic [TAG_W-1:0]  base_tag_in;
   logic              base_rdy_in;
   logic [31:0]       offset_in;
   logic [2:0]        mem_u_b_h_w_in;
   logic [TAG_W+32:0] cdb;
   logic              mem_ready;
   logic              FU_result_taken;
   logic              full;
   logic [IDX_W-1:0]  alloc_idx;
   logic              mem_valid;
   logic [31:0]       mem_addr;
   logic [2:0]        mem_u_b_h_w;
   logic [IDX_W-1:0]  mem_idx;
   logic [DEPTH-1:0]  busy_vec;

   int assert_count = 0;
   int fail_count   = 0;

   rs_load_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .issue(issue), .base_val_in(base_val_in),
      .base_tag_in(base_tag_in), .base_rdy_in(base_rdy_in), .offset_in(offset_in),
      .mem_u_b_h_w_in(mem_u_b_h_w_in), .cdb(cdb), .mem_ready(mem_ready),
      .FU_result_taken(FU_result_taken), .full(full), .alloc_idx(alloc_idx),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_u_b_h_w(mem_u_b_h_w),
      .mem_idx(mem_idx), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_load(input logic [31:0] b, input logic [TAG_W-1:0] t, input logic r,
                             input logic [31:0] o, input logic [2:0] ty);
      issue          = 1'b1;
      base_val_in    = b;
      base_tag_in    = t;
      base_rdy_in    = r;
      offset_in      = o;
      mem_u_b_h_w_in = ty;
      tick();
      issue = 1'b0;
      cdb   = '0;
   endtask

   task automatic dispatch_one();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
   endtask

   task automatic free_one();
      FU_result_taken = 1'b1;
      tick();
      FU_result_taken = 1'b0;
   endtask

   initial begin
      rst = 1'b1; issue = 1'b0; base_val_in = '0; base_tag_in = '0; base_rdy_in = 1'b0;
      offset_in = '0; mem_u_b_h_w_in = '0; cdb = '0; mem_ready = 1'b0; FU_result_taken = 1'b0;
      #12;
      check_output("rst_full", 32'(full), 32'd0);
      check_output("rst_alloc", 32'(alloc_idx), 32'd0);
      check_output("rst_valid", 32'(mem_valid), 32'd0);
      check_output("rst_addr", mem_addr, 32'd0);
      check_output("rst_busy", 32'(busy_vec), 32'd0);
      #1 rst = 1'b0;
      tick();

      // One load end to end
      issue_load(32'h1000, 8'h00, 1'b1, 32'h10, 3'b010);
      check_output("one_valid", 32'(mem_valid), 32'd1);
      check_output("one_addr", mem_addr, 32'h1010);
      check_output("one_idx", 32'(mem_idx), 32'd0);
      check_output("one_type", 32'(mem_u_b_h_w), 32'd2);
      check_output("one_alloc", 32'(alloc_idx), 32'd1);
      dispatch_one();
      check_output("one_exec_valid", 32'(mem_valid), 32'd0);
      check_output("one_exec_busy", 32'(busy_vec), 32'b0001);
      free_one();
      check_output("one_busy", 32'(busy_vec), 32'd0);

      // Fill with pending tag 0x05, then overflow
      for (int k = 0; k < DEPTH; k++) begin
         issue_load(32'h0, 8'h05, 1'b0, 32'(4 * k), 3'b001);
         check_output("fill_wait_valid", 32'(mem_valid), 32'd0);
      end
      check_output("fill_full", 32'(full), 32'd1);
      check_output("fill_busy", 32'(busy_vec), 32'b1111);
      check_output("fill_alloc", 32'(alloc_idx), 32'd0);
      issue_load(32'h9999, 8'h00, 1'b1, 32'h0, 3'b111);
      check_output("ovf_busy", 32'(busy_vec), 32'b1111);
      check_output("ovf_valid", 32'(mem_valid), 32'd0);

      // One CDB broadcast wakes everything; drain in age order
      cdb = {1'b1, 8'h05, 32'h2000};
      tick();
      cdb = '0;
      for (int k = 0; k < DEPTH; k++) begin
         check_output("drain_valid", 32'(mem_valid), 32'd1);
         check_output("drain_idx", 32'(mem_idx), 32'(k));
         check_output("drain_addr", mem_addr, 32'h2000 + 32'(4 * k));
         dispatch_one();
         free_one();
      end
      check_output("drain_busy", 32'(busy_vec), 32'd0);

      // Issue-cycle bypass
      cdb = {1'b1, 8'h07, 32'h3000};
      issue_load(32'h0, 8'h07, 1'b0, 32'h20, 3'b000);
      check_output("byp_valid", 32'(mem_valid), 32'd1);
      check_output("byp_addr", mem_addr, 32'h3020);
      dispatch_one();
      free_one();

      // Age priority: A waits, B and C ready; expected order B, C, A
      issue_load(32'h0, 8'h01, 1'b0, 32'h0, 3'b000);
      issue_load(32'h100, 8'h00, 1'b1, 32'h0, 3'b000);
      issue_load(32'h200, 8'h00, 1'b1, 32'h0, 3'b000);
      check_output("age_first_idx", 32'(mem_idx), 32'd1);
      check_output("age_first_addr", mem_addr, 32'h100);
      dispatch_one();
      free_one();
      check_output("age_second_idx", 32'(mem_idx), 32'd2);
      mem_ready = 1'b1;
      cdb = {1'b1, 8'h01, 32'h300};
      tick();
      mem_ready = 1'b0;
      cdb = '0;
      check_output("age_exec_block", 32'(mem_valid), 32'd0);
      free_one();
      check_output("age_third_idx", 32'(mem_idx), 32'd0);
      check_output("age_third_addr", mem_addr, 32'h300);
      dispatch_one();
      free_one();
      check_output("age_busy", 32'(busy_vec), 32'd0);

      // Address wrap, then issue concurrent with free
      issue_load(32'h1, 8'h00, 1'b1, 32'hFFFF_FFFF, 3'b011);
      check_output("wrap_addr", mem_addr, 32'h0);
      check_output("wrap_valid", 32'(mem_valid), 32'd1);
      dispatch_one();
      issue_load(32'h0, 8'h09, 1'b0, 32'h0, 3'b000);
      issue_load(32'h40, 8'h00, 1'b1, 32'h0, 3'b101);
      check_output("cofree_alloc", 32'(alloc_idx), 32'd3);
      FU_result_taken = 1'b1;
      issue_load(32'h80, 8'h00, 1'b1, 32'h0, 3'b100);
      FU_result_taken = 1'b0;
      check_output("cofree_busy", 32'(busy_vec), 32'b1110);
      check_output("cofree_alloc2", 32'(alloc_idx), 32'd0);
      check_output("cofree_idx", 32'(mem_idx), 32'd2);
      check_output("cofree_addr", mem_addr, 32'h40);
      dispatch_one();
      free_one();
      check_output("dense_idx", 32'(mem_idx), 32'd3);
      check_output("dense_type", 32'(mem_u_b_h_w), 32'd4);
      cdb = {1'b1, 8'h09, 32'h500};
      tick();
      cdb = '0;
      check_output("dense_oldest_idx", 32'(mem_idx), 32'd1);
      check_output("dense_oldest_addr", mem_addr, 32'h500);

      // Reset with one EXEC and two WAIT entries outstanding
      dispatch_one();
      issue_load(32'h0, 8'h33, 1'b0, 32'h4, 3'b001);
      issue_load(32'h0, 8'h33, 1'b0, 32'h8, 3'b001);
      check_output("pre_rst_busy", 32'(busy_vec), 32'b1111);
      check_output("pre_rst_addr", mem_addr, 32'h80);
      #2 rst = 1'b1;
      #1;
      check_output("mid_rst_full", 32'(full), 32'd0);
      check_output("mid_rst_alloc", 32'(alloc_idx), 32'd0);
      check_output("mid_rst_valid", 32'(mem_valid), 32'd0);
      check_output("mid_rst_addr", mem_addr, 32'd0);
      check_output("mid_rst_type", 32'(mem_u_b_h_w), 32'd0);
      check_output("mid_rst_idx", 32'(mem_idx), 32'd0);
      check_output("mid_rst_busy", 32'(busy_vec), 32'd0);
      #3 rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/rs_load_buffer.md
# rs_load_buffer

Multi-entry load reservation station for the Tomasulo core. It replaces the single-line load RS with `DEPTH` entries. Each entry captures a base operand and an immediate offset, and snoops the CDB for a pending base tag. Once the base is known it forms the effective address and dispatches loads oldest-ready-first to the single memory FU over a valid/ready handshake. An entry frees when the FU result is taken by the CDB arbiter.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; a power of two, from 2 to 16.
- `TAG_W`, 8: producer tag width. The CDB width is 1+`TAG_W`+32.
- `IDX_W`, $clog2(`DEPTH`): entry index width.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `issue`  in  1  allocates an entry this cycle.
- `base_val_in`  in  32  base register value, valid when `base_rdy_in` is 1.
- `base_tag_in`  in  `TAG_W`  producer tag of the base, used when `base_rdy_in` is 0.
- `base_rdy_in`  in  1  base value is available at issue.
- `offset_in`  in  32  sign-extended immediate.
- `mem_u_b_h_w_in`  in  3  load type, stored unmodified.
- `cdb`  in  41  broadcast bus {valid[40], tag[39:32], data[31:0]} with the default `TAG_W`.
- `mem_ready`  in  1  the memory FU accepts a request.
- `FU_result_taken`  in  1  the CDB arbiter has consumed the in-flight load result.
- `full`  out  1  no free entry.
- `alloc_idx`  out  `IDX_W`  index the next `issue` will occupy. This is the lowest free index; it is 0 when `full` is 1.
- `mem_valid`  out  1  dispatch request.
- `mem_addr`  out  32  effective address, base+offset mod 2^32.
- `mem_u_b_h_w`  out  3  load type of the dispatched entry.
- `mem_idx`  out  `IDX_W`  index of the dispatched entry.
- `busy_vec`  out  `DEPTH`  per-entry busy bits.

## Operation
- **Entry states:** FREE, WAIT (base pending), READY (base known), EXEC (sent to the FU, awaiting result taken). Busy means the entry is not FREE.
- **Reset:** all entries go to FREE, all fields to 0 and all age ranks to 0. The outputs reset to `full`=0, `alloc_idx`=0, `mem_valid`=0, `mem_addr`=0, `mem_u_b_h_w`=0, `mem_idx`=0 and `busy_vec`=0.
- **Issue** (`issue` & !`full`):
  - Entry `alloc_idx` stores the offset and the type, and gets age rank = current occupancy.
  - If `base_rdy_in` is 1, the entry goes to READY with `base_val_in`.
  - If `base_rdy_in` is 0 and `cdb` is valid with a tag equal to `base_tag_in`, the entry goes to READY with the CDB data (issue-cycle bypass).
  - Otherwise the entry goes to WAIT with `base_tag_in`.
  - `issue` while `full` is ignored and changes no state.
- **Snoop:** every WAIT entry whose tag equals a valid `cdb` tag captures `cdb[31:0]` and goes to READY. Multiple entries may wake in the same cycle.
- **Dispatch:**
  - `mem_valid` is 1 when no entry is in EXEC and at least one entry is READY.
  - The selected entry is the READY entry with the smallest age rank. This is combinational over registered state.
  - `mem_addr` = base+offset of the selected entry; carry out is discarded.
  - On `mem_valid` & `mem_ready` the selected entry goes to EXEC.
  - At most one entry is in EXEC at any time.
- **Free:**
  - `FU_result_taken` moves the EXEC entry to FREE.
  - Every entry with a rank greater than the freed entry's rank decrements its rank by 1.
  - `FU_result_taken` with no EXEC entry is ignored.
- **Simultaneous events:**
  - Issue and free in the same cycle: the new entry's rank = occupancy − 1, so ranks stay dense.
  - A slot freed this cycle is not allocatable until the next cycle, because `full` and `alloc_idx` come from registered state.
  - If free and dispatch are both possible in the same cycle, dispatch waits until the next cycle, since `mem_valid` requires no EXEC entry on registered state.
  - A CDB wake and a dispatch of a different entry may occur in the same cycle.
- **Ordering:** loads dispatch oldest-ready-first, not strictly in program order. Memory disambiguation is the store buffer's job.

## Timing
- Issue with a ready base: the entry is READY at the next edge, and `mem_valid` is visible in the following cycle (1-cycle issue→request).
- CDB wake: 1 cycle to READY. The request can follow in the next cycle.
- Request → EXEC on the accepting edge; `mem_valid` deasserts in the next cycle.
- `FU_result_taken` frees the entry at the next edge; `full` drops in the same following cycle.
- Throughput: one load per 2 cycles at best (dispatch, then free). The FU handles the rest.
- Asynchronous `rst` mid-operation clears everything, including an EXEC entry. The FU must be reset along with this block.

## Test plan
- **Reset, then one load.** Release reset, then issue base=0x1000 (ready), offset=0x10, type=3'b010 → `mem_valid`=1, `mem_addr`=0x1010, `mem_idx`=0. Assert `mem_ready`, then `FU_result_taken` → `busy_vec`=0.
- **Fill and overflow.** Issue `DEPTH`=4 loads, all with a pending tag 0x05 → `full`=1, `busy_vec`=4'b1111. A 5th `issue` → no state change.
- **Snoop and bypass.** A CDB {1,0x05,0x2000} wakes all four entries. An issue with tag 0x07 in the same cycle as CDB tag 0x07 → READY with the CDB data.
- **Age priority.** Issue A (tag 0x1), B (ready), C (ready). B dispatches first. A's wake does not pass C: the order is B, C, A.
- **Wrap.** offset=0xFFFFFFFF, base=0x1 → `mem_addr`=0x0. After a free with a simultaneous issue, ranks stay dense and the next dispatch is the oldest READY entry.
- **Reset mid-operation.** Assert `rst` with one EXEC and two WAIT entries → all outputs are 0 immediately, with no clock edge required.
